// File: rtl/stream_harness.sv
// Stream source and order-based affine checker for single-in/single-out accelerators.
// Optional first-error capture ports are enabled by defining STREAM_HARNESS_CAPTURE_EN.
module stream_harness #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned LANES        = 1,
  parameter int unsigned START        = 0,
  parameter int unsigned STEP         = 1,
  parameter int unsigned SCALE        = 1,
  parameter int unsigned OFFSET       = 0,
  parameter int unsigned EXPECT_COUNT = 4096,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_read_en,
  output logic [LANES*WIDTH-1:0]   in_data,
  input  logic                     out_write_valid,
  input  logic [LANES*WIDTH-1:0]   out_data,
  output logic [CNT_W-1:0]         out_count,
  output logic [15:0]              err_count,
  output logic                     running,
  output logic                     done,
  output logic                     pass,
  output logic                     timed_out
`ifdef STREAM_HARNESS_CAPTURE_EN
  ,
  output logic [CNT_W-1:0]         first_err_beat,
  output logic [7:0]               first_err_lane,
  output logic [WIDTH-1:0]         first_err_got,
  output logic [WIDTH-1:0]         first_err_exp
`endif
);

  localparam logic [WIDTH-1:0] StartVal  = WIDTH'(START);
  localparam logic [WIDTH-1:0] BeatAdv   = WIDTH'(LANES * STEP);
  localparam logic [WIDTH-1:0] ScaleVal  = WIDTH'(SCALE);
  localparam logic [WIDTH-1:0] OffsetVal = WIDTH'(OFFSET);
  localparam logic [CNT_W-1:0] ExpCnt    = CNT_W'(EXPECT_COUNT);
  localparam logic [CNT_W-1:0] IdleMax   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StTimeout} state_e;

  function automatic logic [LANES*WIDTH-1:0] lanes_of(input logic [WIDTH-1:0] base);
    logic [LANES*WIDTH-1:0] r;
    r = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      r[l*WIDTH +: WIDTH] = base + WIDTH'(l * STEP);
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       gen_q, gen_d;
  logic [WIDTH-1:0]       exp_q, exp_d;
  logic [LANES*WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       idle_q, idle_d;
  logic [15:0]            err_q, err_d;
  logic                   ovf_q, ovf_d;

  logic [WIDTH-1:0]       exp_lane [LANES];
  logic [LANES-1:0]       mism;
  logic [16:0]            err_sum;
  logic [15:0]            err_sat;
  logic                   accept;

  always_comb begin
    mism = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      exp_lane[l] = (exp_q + WIDTH'(l * STEP)) * ScaleVal + OffsetVal;
      mism[l]     = out_data[l*WIDTH +: WIDTH] != exp_lane[l];
    end
    err_sum = {1'b0, err_q} + 17'($countones(mism));
    err_sat = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_comb begin
    state_d = state_q;
    gen_d   = gen_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;
    // The source advances in every state; only flush/reset restarts it.
    if (in_read_en) gen_d = gen_q + BeatAdv;
    case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (EXPECT_COUNT == 0) begin
          state_d = StDone;
        end else if (out_write_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          err_d  = err_sat;
          exp_d  = exp_q + BeatAdv;
          idle_d = '0;
          if (cnt_d == ExpCnt) state_d = StDone;
        end else if (idle_q == IdleMax) begin
          state_d = StTimeout;
        end else begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
      StDone:    if (out_write_valid) ovf_d = 1'b1;
      StTimeout: ;
      default:   state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
      gen_d   = StartVal;
      exp_d   = StartVal;
      cnt_d   = '0;
      idle_d  = '0;
      err_d   = '0;
      ovf_d   = 1'b0;
      accept  = 1'b0;
    end
    data_d = lanes_of(gen_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gen_q   <= StartVal;
      exp_q   <= StartVal;
      data_q  <= lanes_of(StartVal);
      cnt_q   <= '0;
      idle_q  <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      exp_q   <= exp_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_data   = data_q;
  assign out_count = cnt_q;
  assign err_count = err_q;
  assign running   = state_q == StRun;
  assign done      = (state_q == StDone) || (state_q == StTimeout);
  assign pass      = (state_q == StDone) && (err_q == 16'h0) && !ovf_q;
  assign timed_out = state_q == StTimeout;

`ifdef STREAM_HARNESS_CAPTURE_EN
  logic             cap_vld_q, cap_vld_d;
  logic [CNT_W-1:0] cap_beat_q, cap_beat_d;
  logic [7:0]       cap_lane_q, cap_lane_d;
  logic [WIDTH-1:0] cap_got_q, cap_got_d;
  logic [WIDTH-1:0] cap_exp_q, cap_exp_d;
  logic [7:0]       low_lane;

  always_comb begin
    low_lane = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (mism[l]) low_lane = 8'(l);
    end
    cap_vld_d  = cap_vld_q;
    cap_beat_d = cap_beat_q;
    cap_lane_d = cap_lane_q;
    cap_got_d  = cap_got_q;
    cap_exp_d  = cap_exp_q;
    // Beat index is zero-based: the count of beats accepted before this one.
    if (accept && |mism && !cap_vld_q) begin
      cap_vld_d  = 1'b1;
      cap_beat_d = cnt_q;
      cap_lane_d = low_lane;
      cap_got_d  = out_data[low_lane*WIDTH +: WIDTH];
      cap_exp_d  = exp_lane[low_lane];
    end
    if (flush) begin
      cap_vld_d  = 1'b0;
      cap_beat_d = '0;
      cap_lane_d = '0;
      cap_got_d  = '0;
      cap_exp_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld_q  <= 1'b0;
      cap_beat_q <= '0;
      cap_lane_q <= '0;
      cap_got_q  <= '0;
      cap_exp_q  <= '0;
    end else begin
      cap_vld_q  <= cap_vld_d;
      cap_beat_q <= cap_beat_d;
      cap_lane_q <= cap_lane_d;
      cap_got_q  <= cap_got_d;
      cap_exp_q  <= cap_exp_d;
    end
  end

  assign first_err_beat = cap_beat_q;
  assign first_err_lane = cap_lane_q;
  assign first_err_got  = cap_got_q;
  assign first_err_exp  = cap_exp_q;
`endif

endmodule
